// File: rtl/ysyx_23060236_icache_ctrl.sv
// Instruction-cache refill controller: looks up IFU fetches, refills a
// 32-byte block over an AXI4 INCR burst on a miss, returns the instruction,
// and sequences fence.i invalidation of the array.
module ysyx_23060236_icache_ctrl #(
    parameter int unsigned BEAT_CNT = 8,
    parameter int unsigned CADDR_W  = 25
) (
    input  logic               clock,
    input  logic               reset,
    // IFU side
    input  logic               ifu_req_valid,
    output logic               ifu_req_ready,
    input  logic [31:0]        ifu_addr,
    output logic               ifu_resp_valid,
    input  logic               ifu_resp_ready,
    output logic [31:0]        ifu_rdata,
    output logic               ifu_resp_err,
    input  logic               fencei_req,
    // icache array side
    output logic [CADDR_W-1:0] icache_araddr,
    input  logic [31:0]        icache_rdata,
    input  logic               icache_hit,
    output logic [CADDR_W-1:0] icache_awaddr,
    output logic [31:0]        icache_wdata,
    output logic               icache_wvalid,
    output logic               icache_fencei,
    // AXI4 read channels
    output logic               arvalid,
    input  logic               arready,
    output logic [31:0]        araddr,
    output logic [7:0]         arlen,
    output logic [2:0]         arsize,
    output logic [1:0]         arburst,
    input  logic               rvalid,
    output logic               rready,
    input  logic [31:0]        rdata,
    input  logic [1:0]         rresp,
    input  logic               rlast,
    // performance counters
    output logic [31:0]        perf_hit,
    output logic [31:0]        perf_miss
);

    localparam int unsigned CNT_W = $clog2(BEAT_CNT);
    localparam int unsigned OFF_W = CNT_W + 2;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEAT_CNT - 1);
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_AR     = 3'd2;
    localparam logic [2:0] S_R      = 3'd3;
    localparam logic [2:0] S_FLUSH  = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [31:0]      perf_hit_q, perf_hit_d;
    logic [31:0]      perf_miss_q, perf_miss_d;

    logic             at_last_c;
    logic             final_beat_c;
    logic             beat_bad_c;

    // Fixed burst shape and address views of the latched PC
    assign arlen         = 8'(BEAT_CNT - 1);
    assign arsize        = 3'b010;
    assign arburst       = 2'b01;
    assign icache_araddr = pc_q[CADDR_W-1:0];
    assign araddr        = {pc_q[31:OFF_W], OFF_W'(0)};
    assign perf_hit      = perf_hit_q;
    assign perf_miss     = perf_miss_q;

    // Beat classification: a burst must end exactly on the last word
    assign at_last_c    = (cnt_q == LAST_CNT);
    assign final_beat_c = rlast || at_last_c;
    assign beat_bad_c   = (rresp != 2'b00) || (rlast != at_last_c);

    // Next-state and output decode
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        perf_hit_d    = perf_hit_q;
        perf_miss_d   = perf_miss_q;
        ifu_req_ready = 1'b0;
        ifu_resp_valid = 1'b0;
        ifu_rdata     = 32'd0;
        ifu_resp_err  = 1'b0;
        icache_awaddr = '0;
        icache_wdata  = 32'd0;
        icache_wvalid = 1'b0;
        icache_fencei = 1'b0;
        arvalid       = 1'b0;
        rready        = 1'b0;

        case (state_q)
            S_IDLE: begin
                ifu_req_ready = !fencei_req;
                if (fencei_req) begin
                    err_d   = 1'b0;
                    state_d = S_FLUSH;
                end else if (ifu_req_valid) begin
                    pc_d    = ifu_addr;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                err_d = 1'b0;
                if (icache_hit) begin
                    if (perf_hit_q != CNT_MAX) perf_hit_d = perf_hit_q + 32'd1;
                    state_d = S_RESP;
                end else begin
                    if (perf_miss_q != CNT_MAX) perf_miss_d = perf_miss_q + 32'd1;
                    cnt_d   = '0;
                    state_d = S_AR;
                end
            end
            S_AR: begin
                arvalid = 1'b1;
                if (arready) state_d = S_R;
            end
            S_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    icache_wvalid = 1'b1;
                    icache_awaddr = {pc_q[CADDR_W-1:OFF_W], cnt_q, 2'b00};
                    icache_wdata  = rdata;
                    cnt_d         = cnt_q + CNT_W'(1);
                    err_d         = err_q || beat_bad_c;
                    if (final_beat_c) state_d = (err_q || beat_bad_c) ? S_FLUSH : S_RESP;
                end
            end
            S_FLUSH: begin
                // A failed refill also invalidates, so the partial line never hits
                icache_fencei = 1'b1;
                state_d       = err_q ? S_RESP : S_IDLE;
            end
            S_RESP: begin
                ifu_resp_valid = 1'b1;
                ifu_rdata      = icache_rdata;
                ifu_resp_err   = err_q;
                if (ifu_resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, request context and counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= 32'd0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            perf_hit_q  <= 32'd0;
            perf_miss_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            perf_hit_q  <= perf_hit_d;
            perf_miss_q <= perf_miss_d;
        end
    end

endmodule

// File: tb/tb_ysyx_23060236_icache_ctrl.sv
// Bench for the icache refill controller: provides an icache array and an
// AXI memory, tracks which blocks must be resident, and checks every cycle.
module tb_ysyx_23060236_icache_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid, ifu_resp_ready;
    logic [31:0] ifu_rdata;
    logic        ifu_resp_err;
    logic        fencei_req;
    logic [24:0] icache_araddr, icache_awaddr;
    logic [31:0] icache_rdata, icache_wdata;
    logic        icache_hit, icache_wvalid, icache_fencei;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [31:0] perf_hit, perf_miss;

    always #5 clock = ~clock;

    ysyx_23060236_icache_ctrl dut (
        .clock(clock), .reset(reset),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
        .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err), .fencei_req(fencei_req),
        .icache_araddr(icache_araddr), .icache_rdata(icache_rdata), .icache_hit(icache_hit),
        .icache_awaddr(icache_awaddr), .icache_wdata(icache_wdata),
        .icache_wvalid(icache_wvalid), .icache_fencei(icache_fencei),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .perf_hit(perf_hit), .perf_miss(perf_miss)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Icache array: 2 sets x 8 words, combinational lookup
    logic        arr_valid [2];
    logic [18:0] arr_tag   [2];
    logic [31:0] arr_data  [16];

    assign icache_hit   = arr_valid[icache_araddr[5]] && (arr_tag[icache_araddr[5]] == icache_araddr[24:6]);
    assign icache_rdata = arr_data[{icache_araddr[5], icache_araddr[4:2]}];

    // Array update: writes and invalidation land on the clock edge
    initial begin : env_array
        logic        w, f;
        logic [24:0] wa;
        logic [31:0] wd;
        for (int i = 0; i < 2; i++) begin arr_valid[i] = 1'b0; arr_tag[i] = 19'd0; end
        for (int i = 0; i < 16; i++) arr_data[i] = 32'd0;
        forever begin
            @(negedge clock);
            w = icache_wvalid; wa = icache_awaddr; wd = icache_wdata; f = icache_fencei;
            @(posedge clock); #1;
            if (w) begin
                arr_data[{wa[5], wa[4:2]}] = wd;
                arr_tag[wa[5]]   = wa[24:6];
                arr_valid[wa[5]] = 1'b1;
            end
            if (f || reset) begin arr_valid[0] = 1'b0; arr_valid[1] = 1'b0; end
        end
    end

    // AXI memory: configurable AR delay, gapped beats and an error beat
    int ar_delay  = 0;
    int err_beat  = -1;
    bit gap_mode  = 1'b0;

    initial begin : axi_slave
        logic        ar_hs, r_hs, in_burst, phase;
        int          beat, ar_wait;
        logic [31:0] base;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00; rlast = 1'b0;
        in_burst = 1'b0; phase = 1'b0; beat = 0; ar_wait = 0; base = 32'd0;
        forever begin
            @(negedge clock);
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            if (ar_hs) base = araddr;
            @(posedge clock); #1;
            if (r_hs) begin beat++; if (beat == 8) in_burst = 1'b0; end
            if (ar_hs) begin in_burst = 1'b1; beat = 0; ar_wait = 0; phase = 1'b0; end
            if (reset) begin in_burst = 1'b0; ar_wait = 0; end
            arready = 1'b0;
            if (!in_burst && arvalid && !reset) begin
                if (ar_wait >= ar_delay) arready = 1'b1;
                else ar_wait++;
            end
            rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rdata = 32'd0;
            if (in_burst) begin
                phase = !phase;
                if (!gap_mode || !phase) begin
                    rvalid = 1'b1;
                    rdata  = mem_word(base + 32'(beat * 4));
                    rresp  = (beat == err_beat) ? 2'b10 : 2'b00;
                    rlast  = (beat == 7);
                end
            end
        end
    end

    // Model state: expected context of the current fetch and resident blocks
    logic [31:0] cur_pc    = 32'd0;
    logic [31:0] exp_rdata = 32'd0;
    logic        exp_err   = 1'b0;
    bit          res_valid [2];
    logic [18:0] res_tag   [2];
    int          hits = 0, misses = 0;
    int          mon_beat = 0, fencei_cnt = 0, ar_cnt = 0;
    logic [31:0] ar_seen = 32'd0;
    logic [31:0] last_rdata;
    logic        last_err;

    // Per-cycle compare against the model
    initial begin : compare
        logic        p_arv, p_arr, p_rv, p_rr, p_err;
        logic [31:0] p_ara, p_rd;
        p_arv = 1'b0; p_arr = 1'b0; p_rv = 1'b0; p_rr = 1'b0; p_err = 1'b0;
        p_ara = 32'd0; p_rd = 32'd0;
        forever begin
            @(negedge clock); #2;
            if (reset) begin
                p_arv = 1'b0; p_rv = 1'b0;
            end else begin
                chk("arlen", 32'(arlen), 32'd7);
                chk("arsize", 32'(arsize), 32'd2);
                chk("arburst", 32'(arburst), 32'd1);
                if (p_arv && !p_arr) begin
                    chk("arvalid_hold", 32'(arvalid), 32'd1);
                    chk("araddr_hold", araddr, p_ara);
                end
                if (arvalid) chk("araddr", araddr, cur_pc & ~32'h1F);
                if (arvalid && arready) begin ar_cnt++; ar_seen = araddr; mon_beat = 0; end
                chk("wvalid", 32'(icache_wvalid), 32'(rvalid && rready));
                if (rvalid && rready) begin
                    chk("awaddr", 32'(icache_awaddr), 32'(cur_pc[24:0] & ~25'h1F) + 32'(mon_beat * 4));
                    chk("wdata", icache_wdata, rdata);
                    mon_beat++;
                end
                if (icache_fencei) fencei_cnt++;
                if (p_rv && !p_rr) begin
                    chk("resp_valid_hold", 32'(ifu_resp_valid), 32'd1);
                    chk("resp_rdata_hold", ifu_rdata, p_rd);
                    chk("resp_err_hold", 32'(ifu_resp_err), 32'(p_err));
                end
                if (ifu_resp_valid) begin
                    chk("resp_err", 32'(ifu_resp_err), 32'(exp_err));
                    if (!exp_err) chk("resp_rdata", ifu_rdata, exp_rdata);
                    chk("lookup_addr", 32'(icache_araddr), 32'(cur_pc[24:0]));
                end
                p_arv = arvalid; p_arr = arready; p_ara = araddr;
                p_rv = ifu_resp_valid; p_rr = ifu_resp_ready; p_rd = ifu_rdata; p_err = ifu_resp_err;
            end
        end
    end

    task automatic model_flush();
        res_valid[0] = 1'b0; res_valid[1] = 1'b0;
    endtask

    // One fetch: request, wait for response, optional back-pressure, update model
    task automatic fetch(input logic [31:0] pc, input bit exp_hit, input int ebeat,
                         input int ardly, input bit gap, input int hold, input int exp_lat);
        int lat, ar0, f0;
        bit mhit, got;
        ar_delay = ardly; err_beat = ebeat; gap_mode = gap;
        mhit = res_valid[pc[5]] && (res_tag[pc[5]] == pc[24:6]);
        chk("model_hit", 32'(mhit), 32'(exp_hit));
        cur_pc = pc; exp_rdata = mem_word(pc); exp_err = (ebeat >= 0);
        ar0 = ar_cnt; f0 = fencei_cnt;
        @(posedge clock); #1;
        ifu_req_valid = 1'b1; ifu_addr = pc;
        @(negedge clock);
        chk("req_ready", 32'(ifu_req_ready), 32'd1);
        @(posedge clock); #1 ifu_req_valid = 1'b0;
        got = 1'b0; lat = 0;
        for (int n = 1; n <= 200 && !got; n++) begin
            @(negedge clock);
            if (ifu_resp_valid) begin got = 1'b1; lat = n; end
        end
        chk("resp_within_bound", 32'(got), 32'd1);
        if (exp_lat > 0) chk("latency", 32'(lat), 32'(exp_lat));
        last_rdata = ifu_rdata; last_err = ifu_resp_err;
        repeat (hold) @(negedge clock);
        #1 ifu_resp_ready = 1'b1;
        @(posedge clock); #1 ifu_resp_ready = 1'b0;
        if (mhit) hits++;
        else begin
            misses++;
            if (ebeat >= 0) model_flush();
            else begin res_valid[pc[5]] = 1'b1; res_tag[pc[5]] = pc[24:6]; end
        end
        @(posedge clock); #2;
        chk("perf_hit", perf_hit, 32'(hits));
        chk("perf_miss", perf_miss, 32'(misses));
        chk("ar_count", 32'(ar_cnt - ar0), mhit ? 32'd0 : 32'd1);
        chk("fencei_count", 32'(fencei_cnt - f0), (ebeat >= 0) ? 32'd1 : 32'd0);
        chk("back_to_idle", 32'(ifu_req_ready), 32'd1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        int f0;
        bit got;
        reset = 1'b1; ifu_req_valid = 1'b0; ifu_addr = 32'd0; ifu_resp_ready = 1'b0; fencei_req = 1'b0;
        res_valid[0] = 1'b0; res_valid[1] = 1'b0; res_tag[0] = 19'd0; res_tag[1] = 19'd0;
        last_rdata = 32'd0; last_err = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_wvalid", 32'(icache_wvalid), 32'd0);
        chk("rst_resp_valid", 32'(ifu_resp_valid), 32'd0);
        chk("rst_fencei", 32'(icache_fencei), 32'd0);
        chk("rst_icache_araddr", 32'(icache_araddr), 32'd0);
        chk("rst_perf_hit", perf_hit, 32'd0);
        chk("rst_perf_miss", perf_miss, 32'd0);
        chk("rst_arlen", 32'(arlen), 32'd7);
        #1 reset = 1'b0;

        // Cold miss, zero-wait memory
        fetch(32'h3000_0004, 1'b0, -1, 0, 1'b0, 0, 11);
        chk("lit_cold_rdata", last_rdata, 32'hF0DE_0004);
        chk("lit_cold_araddr", ar_seen, 32'h3000_0000);
        chk("lit_cold_miss", perf_miss, 32'd1);

        // Refetch in the same block hits
        fetch(32'h3000_0010, 1'b1, -1, 0, 1'b0, 0, 2);
        chk("lit_hit_rdata", last_rdata, 32'hF0DE_0010);
        chk("lit_hit_count", perf_hit, 32'd1);

        // fence.i wins over a simultaneous request
        f0 = fencei_cnt;
        @(posedge clock); #1;
        fencei_req = 1'b1; ifu_req_valid = 1'b1; ifu_addr = 32'h3000_0004;
        @(negedge clock);
        chk("req_ready_with_fencei", 32'(ifu_req_ready), 32'd0);
        @(posedge clock); #1 fencei_req = 1'b0; ifu_req_valid = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        chk("fencei_pulse", 32'(fencei_cnt - f0), 32'd1);
        chk("fencei_no_resp", 32'(ifu_resp_valid), 32'd0);
        chk("fencei_no_lookup", perf_hit + perf_miss, 32'(hits + misses));
        model_flush();
        fetch(32'h3000_0004, 1'b0, -1, 0, 1'b0, 0, 11);

        // Error on beat 3: burst drained, array flushed, err reported
        fetch(32'h3000_0104, 1'b0, 3, 0, 1'b0, 0, 12);
        chk("lit_err_flag", 32'(last_err), 32'd1);
        fetch(32'h3000_0104, 1'b0, -1, 0, 1'b0, 0, 11);

        // Stalled memory and IFU back-pressure
        fetch(32'h3000_0444, 1'b0, -1, 5, 1'b1, 4, 0);
        fetch(32'h3000_0440, 1'b1, -1, 0, 1'b0, 2, 2);
        fetch(32'h3000_0024, 1'b0, -1, 2, 1'b1, 1, 0);
        fetch(32'h3000_045C, 1'b1, -1, 0, 1'b0, 0, 2);

        // Reset during beat 4 of a refill
        ar_delay = 0; err_beat = -1; gap_mode = 1'b0;
        cur_pc = 32'h3000_0200; exp_rdata = mem_word(32'h3000_0200); exp_err = 1'b0;
        mon_beat = 0;
        @(posedge clock); #1;
        ifu_req_valid = 1'b1; ifu_addr = 32'h3000_0200;
        @(posedge clock); #1 ifu_req_valid = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(posedge clock); #2;
            if (mon_beat == 4) got = 1'b1;
        end
        chk("reached_beat4", 32'(got), 32'd1);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("midrst_arvalid", 32'(arvalid), 32'd0);
        chk("midrst_rready", 32'(rready), 32'd0);
        chk("midrst_wvalid", 32'(icache_wvalid), 32'd0);
        chk("midrst_resp_valid", 32'(ifu_resp_valid), 32'd0);
        chk("midrst_idle", 32'(ifu_req_ready), 32'd1);
        #1 reset = 1'b0;
        model_flush();
        hits = 0; misses = 0;
        fetch(32'h3000_0200, 1'b0, -1, 0, 1'b0, 0, 11);
        chk("lit_post_reset_miss", perf_miss, 32'd1);
        chk("lit_post_reset_rdata", last_rdata, 32'hF0DE_0200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
